// File: rtl/dwt_pkg.sv
// dwt_pkg: shared state/mode encoding and parameter legality helpers for the 2-D DWT sequencer
package dwt_pkg;
   typedef enum logic [1:0] {S_IDLE, S_ROW, S_COL, S_OUT} state_t;
   localparam logic MODE_ROW = 1'b0;
   localparam logic MODE_COL = 1'b1;
   function automatic int addr_w(int width, int height);
      return $clog2(width * height);
   endfunction
   function automatic int line_w(int width, int height);
      return $clog2(width > height ? width : height);
   endfunction
   function automatic logic params_ok(int width, int height, int levels);
      return levels >= 1 && levels <= 4 && (width & (width - 1)) == 0 && (height & (height - 1)) == 0 &&
             width >= (2 << levels) && height >= (2 << levels);
   endfunction
endpackage

// File: rtl/dwt_bank_ram.sv
// dwt_bank_ram: image bank with two write ports and a registered pair read port that holds while idle
module dwt_bank_ram #(
   parameter int DATA_W = 8,
   parameter int AW = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we0,
   input  logic [AW-1:0]     waddr0,
   input  logic [DATA_W-1:0] wdata0,
   input  logic              we1,
   input  logic [AW-1:0]     waddr1,
   input  logic [DATA_W-1:0] wdata1,
   input  logic              re,
   input  logic [AW-1:0]     raddr0,
   input  logic [AW-1:0]     raddr1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1
);
   logic [DATA_W-1:0] mem [2**AW];
   // lo/hi writebacks land in different halves, so the two write addresses never collide
   always_ff @(posedge clk) begin
      if (we0) mem[waddr0] <= wdata0;
      if (we1) mem[waddr1] <= wdata1;
   end
   // registered read pair; holding it while re is low keeps stalled outputs stable
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata0 <= '0;
         rdata1 <= '0;
      end else if (re) begin
         rdata0 <= mem[raddr0];
         rdata1 <= mem[raddr1];
      end
   end
endmodule

// File: rtl/dwt2d_sequencer.sv
// dwt2d_sequencer: multi-level 2-D DWT pass sequencer over two image banks with an external filter
module dwt2d_sequencer
   import dwt_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int HEIGHT = 64,
   parameter int DATA_W = 8,
   parameter int LEVELS = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic                         ld_valid,
   output logic                         ld_ready,
   input  logic [DATA_W-1:0]            ld_data,
   output logic                         rd_valid,
   input  logic                         rd_ready,
   output logic [DATA_W-1:0]            rd_pix0,
   output logic [DATA_W-1:0]            rd_pix1,
   output logic                         rd_mode,
   input  logic                         wb_valid,
   input  logic [DATA_W-1:0]            wb_lo,
   input  logic [DATA_W-1:0]            wb_hi,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [DATA_W-1:0]            out_data,
   output logic                         busy,
   output logic                         done,
   output logic [$clog2(LEVELS+1)-1:0]  level
);
   localparam int AW = addr_w(WIDTH, HEIGHT);
   localparam int XW = $clog2(WIDTH);
   localparam int MW = line_w(WIDTH, HEIGHT);
   localparam int LW = $clog2(LEVELS + 1);
   if (!params_ok(WIDTH, HEIGHT, LEVELS)) begin : g_bad_params
      $error("dwt2d_sequencer: WIDTH/HEIGHT must be powers of two >= 2^(LEVELS+1), LEVELS in 1..4");
   end
   state_t state, state_n;
   logic [AW-1:0] ld_ptr, optr, pend, ra0, ra1, lo_addr, hi_addr;
   logic [MW-1:0] il, ix, wl, wk;
   logic [MW:0] w_n, h_n, lines, pairs;
   logic [DATA_W-1:0] b0_r0, b0_r1, b1_r0, b1_r1;
   logic iss_done, oi_done, col, pass, iss_active, re_rd, iss_fire, ix_end, il_end;
   logic wb_acc, wk_end, wl_end, wb_last, re_out, out_issue, out_last, ld_fire, clr;
   assign w_n = (MW+1)'(WIDTH) >> level;
   assign h_n = (MW+1)'(HEIGHT) >> level;
   assign col = state == S_COL;
   assign pass = state == S_ROW || col;
   assign lines = col ? w_n : h_n;
   assign pairs = col ? h_n >> 1 : w_n >> 1;
   assign ix_end = {1'b0, ix} == pairs - 1'b1;
   assign il_end = {1'b0, il} == lines - 1'b1;
   assign wk_end = {1'b0, wk} == pairs - 1'b1;
   assign wl_end = {1'b0, wl} == lines - 1'b1;
   assign iss_active = pass && !iss_done;
   assign re_rd = !rd_valid || rd_ready;
   assign iss_fire = re_rd && iss_active;
   assign wb_acc = wb_valid && pass && pend != '0;
   assign wb_last = wb_acc && wk_end && wl_end;
   assign re_out = !out_valid || out_ready;
   assign out_issue = state == S_OUT && re_out && !oi_done;
   assign out_last = out_valid && out_ready && oi_done;
   assign ld_fire = ld_valid && ld_ready;
   assign clr = state_n != state;
   assign ra0 = col ? (AW'({ix, 1'b0}) << XW) | AW'(il) : (AW'(il) << XW) | AW'({ix, 1'b0});
   assign ra1 = col ? ra0 | (AW'(1) << XW) : ra0 | AW'(1);
   assign lo_addr = col ? (AW'(wk) << XW) | AW'(wl) : (AW'(wl) << XW) | AW'(wk);
   assign hi_addr = col ? lo_addr | (AW'(pairs) << XW) : lo_addr | AW'(pairs);
   assign rd_pix0 = rd_mode ? b1_r0 : b0_r0;
   assign rd_pix1 = rd_mode ? b1_r1 : b0_r1;
   assign out_data = b0_r0;
   // state register
   always_ff @(posedge clk) begin
      state <= rst ? S_IDLE : state_n;
   end
   // next state: each pass ends on its last writeback, the level count picks ROW again or OUT
   always_comb begin
      state_n = state;
      case (state)
         S_IDLE: state_n = start ? S_ROW : S_IDLE;
         S_ROW:  state_n = wb_last ? S_COL : S_ROW;
         S_COL:  state_n = !wb_last ? S_COL : level == LW'(LEVELS - 1) ? S_OUT : S_ROW;
         S_OUT:  state_n = out_last ? S_IDLE : S_OUT;
         default: state_n = S_IDLE;
      endcase
   end
   // state-decoded outputs
   always_comb begin
      busy = state != S_IDLE;
      ld_ready = state == S_IDLE;
   end
   // issue, writeback and output counters; all restart whenever the state changes
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         il <= '0;
         ix <= '0;
         iss_done <= 1'b0;
         wl <= '0;
         wk <= '0;
         pend <= '0;
         optr <= '0;
         oi_done <= 1'b0;
      end else begin
         if (iss_fire) begin
            ix <= ix_end ? '0 : ix + 1'b1;
            if (ix_end) begin
               il <= il + 1'b1;
               iss_done <= il_end;
            end
         end
         if (wb_acc) begin
            wk <= wk_end ? '0 : wk + 1'b1;
            if (wk_end) wl <= wl + 1'b1;
         end
         pend <= pend + AW'(rd_valid && rd_ready) - AW'(wb_acc);
         if (out_issue) begin
            optr <= optr + 1'b1;
            oi_done <= &optr;
         end
      end
   end
   // load pointer and decomposition level
   always_ff @(posedge clk) begin
      if (rst || (state == S_IDLE && start)) begin
         ld_ptr <= '0;
         level <= '0;
      end else begin
         if (ld_fire) ld_ptr <= ld_ptr + 1'b1;
         if (col && wb_last) level <= level + 1'b1;
      end
   end
   // pair/stream valid flags track the registered RAM outputs one cycle behind the read enable
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_valid <= 1'b0;
         rd_mode <= MODE_ROW;
         out_valid <= 1'b0;
         done <= 1'b0;
      end else begin
         if (re_rd) rd_valid <= iss_active;
         if (iss_fire) rd_mode <= col ? MODE_COL : MODE_ROW;
         if (re_out) out_valid <= state == S_OUT && !oi_done;
         done <= out_last;
      end
   end
   dwt_bank_ram #(.DATA_W(DATA_W), .AW(AW)) bank0 (
      .clk(clk), .rst(rst),
      .we0(ld_fire || (col && wb_acc)), .waddr0(state == S_IDLE ? ld_ptr : lo_addr),
      .wdata0(state == S_IDLE ? ld_data : wb_lo),
      .we1(col && wb_acc), .waddr1(hi_addr), .wdata1(wb_hi),
      .re(iss_fire || out_issue), .raddr0(state == S_OUT ? optr : ra0), .raddr1(ra1),
      .rdata0(b0_r0), .rdata1(b0_r1)
   );
   dwt_bank_ram #(.DATA_W(DATA_W), .AW(AW)) bank1 (
      .clk(clk), .rst(rst),
      .we0(state == S_ROW && wb_acc), .waddr0(lo_addr), .wdata0(wb_lo),
      .we1(state == S_ROW && wb_acc), .waddr1(hi_addr), .wdata1(wb_hi),
      .re(iss_fire), .raddr0(ra0), .raddr1(ra1),
      .rdata0(b1_r0), .rdata1(b1_r1)
   );
endmodule
